// File: rtl/pac_man_pkg.sv
// Shared definitions for the Pac-Man position tracking logic.
//   - Board geometry defaults (GRID_W, GRID_H, TUNNEL_ROW) and block index width
//   - tracker_state_t: transaction states of the position tracker
//   - row_of / col_of: split a block index into row and column using
//     shift/mask, which is valid because the board width is a power of two
package pac_man_pkg;

  localparam int GRID_W     = 32;
  localparam int GRID_H     = 30;
  localparam int BLOCK_W    = 10;
  localparam int TUNNEL_ROW = 15;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DONE,
    LOOKUP,
    CHECK
  } tracker_state_t;

  function automatic logic [BLOCK_W-1:0] row_of(input logic [BLOCK_W-1:0] blk,
                                                input int unsigned w_log2);
    return blk >> w_log2;
  endfunction

  function automatic logic [BLOCK_W-1:0] col_of(input logic [BLOCK_W-1:0] blk,
                                                input int unsigned w_log2);
    return blk & BLOCK_W'((1 << w_log2) - 1);
  endfunction

endpackage

// File: rtl/pac_man_position_tracker_if.sv
// Move-proposal handshake between the position tracker and pac_man_behavior.
//   start      : one-cycle request from the tracker
//   ready      : behavior block can accept start
//   done       : next_block is valid this cycle
//   next_block : proposed block index
// Modports: master = tracker side, slave = behavior side.
interface pac_man_position_tracker_if;
  import pac_man_pkg::*;

  logic               start;
  logic               ready;
  logic               done;
  logic [BLOCK_W-1:0] next_block;

  modport master (output start, input ready, input done, input next_block);
  modport slave  (input start, output ready, output done, output next_block);

endinterface

// File: rtl/move_validator.sv
// Combinational classification of a proposed move.
//   curr_block    : committed position
//   cand          : proposed block
//   legal         : cand is in bounds and one step away (or a tunnel wrap)
//   remapped_cand : cand, or the far end of the tunnel row when wrapping
// The equal-position case is not handled here; the caller filters it first.
module move_validator
  import pac_man_pkg::*;
#(
  parameter int GRID_W     = pac_man_pkg::GRID_W,
  parameter int GRID_H     = pac_man_pkg::GRID_H,
  parameter int TUNNEL_ROW = pac_man_pkg::TUNNEL_ROW
) (
  input  logic [BLOCK_W-1:0] curr_block,
  input  logic [BLOCK_W-1:0] cand,
  output logic               legal,
  output logic [BLOCK_W-1:0] remapped_cand
);

  localparam int W_LOG2 = $clog2(GRID_W);
  // One extra bit so that curr_block - step cannot alias a real block index.
  localparam logic [BLOCK_W:0]   STEP_H   = (BLOCK_W+1)'(1);
  localparam logic [BLOCK_W:0]   STEP_V   = (BLOCK_W+1)'(GRID_W);
  localparam logic [BLOCK_W:0]   LIMIT    = (BLOCK_W+1)'(GRID_W * GRID_H);
  localparam logic [BLOCK_W-1:0] LAST_COL = BLOCK_W'(GRID_W - 1);
  localparam logic [BLOCK_W-1:0] TUN_ROW  = BLOCK_W'(TUNNEL_ROW);

  logic [BLOCK_W:0]   cur_x, cand_x;
  logic [BLOCK_W-1:0] row, col;
  logic step_left, step_right, in_bounds, vertical, horizontal;
  logic wrap_left, wrap_right;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    cur_x      = {1'b0, curr_block};
    cand_x     = {1'b0, cand};
    row        = row_of(curr_block, W_LOG2);
    col        = col_of(curr_block, W_LOG2);
    step_left  = (cand_x == cur_x - STEP_H);
    step_right = (cand_x == cur_x + STEP_H);
    in_bounds  = (cand_x < LIMIT);
    vertical   = (cand_x == cur_x + STEP_V) || (cand_x == cur_x - STEP_V);
    // A +/-1 step across a column edge lands on the neighbouring row; only
    // the tunnel row turns that into a wrap.
    horizontal = (step_right && col != LAST_COL) || (step_left && col != '0);
    wrap_left  = step_left  && col == '0       && row == TUN_ROW;
    wrap_right = step_right && col == LAST_COL && row == TUN_ROW;
    legal      = in_bounds && (vertical || horizontal || wrap_left || wrap_right);

    remapped_cand = cand;
    if (wrap_left)       remapped_cand = curr_block | LAST_COL;
    else if (wrap_right) remapped_cand = curr_block & ~LAST_COL;
  end

endmodule

// File: rtl/pac_man_position_tracker.sv
// Authoritative Pac-Man board position.
// Each move tick requests a proposal from the behavior block, validates it
// (adjacency, bounds, tunnel wrap, wall memory lookup) and commits or
// rejects it. All outputs are registered.
//   clk, reset  : clock, asynchronous active-high reset
//   game_en     : game running; low aborts any transaction
//   move_tick   : one-cycle move opportunity
//   beh         : start/ready/done/next_block handshake (master side)
//   wall_addr   : wall memory address; wall_q returns the bit a cycle later
//   curr_block  : committed position
//   moved       : pulse, curr_block changed this cycle
//   blocked     : pulse, proposal rejected
//   fault       : pulse, done timeout or tick dropped while busy
module pac_man_position_tracker
  import pac_man_pkg::*;
#(
  parameter int GRID_W       = pac_man_pkg::GRID_W,
  parameter int GRID_H       = pac_man_pkg::GRID_H,
  parameter int START_BLOCK  = 495,
  parameter int TUNNEL_ROW   = pac_man_pkg::TUNNEL_ROW,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        game_en,
  input  logic                        move_tick,
  pac_man_position_tracker_if.master  beh,
  output logic [BLOCK_W-1:0]          wall_addr,
  input  logic                        wall_q,
  output logic [BLOCK_W-1:0]          curr_block,
  output logic                        moved,
  output logic                        blocked,
  output logic                        fault
);

  localparam int                 CNT_W     = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [BLOCK_W-1:0] START_POS = BLOCK_W'(START_BLOCK);

  tracker_state_t     state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [BLOCK_W-1:0] cand, cand_d;
  logic [BLOCK_W-1:0] curr_d, wall_addr_d;
  logic               start_d, moved_d, blocked_d, fault_d;
  logic               legal;
  logic [BLOCK_W-1:0] remapped_cand;

  move_validator #(
    .GRID_W     (GRID_W),
    .GRID_H     (GRID_H),
    .TUNNEL_ROW (TUNNEL_ROW)
  ) u_move_validator (
    .curr_block    (curr_block),
    .cand          (beh.next_block),
    .legal         (legal),
    .remapped_cand (remapped_cand)
  );

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cand_d      = cand;
    curr_d      = curr_block;
    wall_addr_d = wall_addr;
    start_d     = 1'b0;
    moved_d     = 1'b0;
    blocked_d   = 1'b0;
    fault_d     = 1'b0;

    unique case (state)
      IDLE: begin
        if (move_tick && game_en && beh.ready) begin
          state_d = REQ;
          start_d = 1'b1;
        end
      end
      REQ: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        if (beh.done) begin
          if (beh.next_block == curr_block) begin
            state_d = IDLE;
          end else if (legal) begin
            // Register the address now so it is on the bus during LOOKUP.
            cand_d      = remapped_cand;
            wall_addr_d = remapped_cand;
            state_d     = LOOKUP;
          end else begin
            blocked_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LOOKUP: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (wall_q) begin
          blocked_d = 1'b1;
        end else begin
          curr_d  = cand;
          moved_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A tick while busy is dropped; OR-ing keeps a coincident timeout to one pulse.
    if (move_tick && state != IDLE) fault_d = 1'b1;

    // Game stop overrides everything computed above.
    if (!game_en) begin
      state_d     = IDLE;
      curr_d      = curr_block;
      wall_addr_d = wall_addr;
      start_d     = 1'b0;
      moved_d     = 1'b0;
      blocked_d   = 1'b0;
      fault_d     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= START_POS;
      curr_block <= START_POS;
      wall_addr  <= START_POS;
      beh.start  <= 1'b0;
      moved      <= 1'b0;
      blocked    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cand       <= cand_d;
      curr_block <= curr_d;
      wall_addr  <= wall_addr_d;
      beh.start  <= start_d;
      moved      <= moved_d;
      blocked    <= blocked_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_pac_man_position_tracker.sv
// Self-checking bench for pac_man_position_tracker: directed steps followed by
// random proposals, checked against a row/column model of the board rules.
module tb_pac_man_position_tracker;
  import pac_man_pkg::*;

  localparam int DONE_TIMEOUT = 64;
  localparam int START_BLOCK  = 495;
  localparam int NUM_BLOCKS   = GRID_W * GRID_H;

  logic               clk = 1'b0;
  logic               reset;
  logic               game_en;
  logic               move_tick;
  logic [BLOCK_W-1:0] wall_addr;
  logic               wall_q;
  logic [BLOCK_W-1:0] curr_block;
  logic               moved, blocked, fault;

  pac_man_position_tracker_if bus ();

  pac_man_position_tracker #(
    .GRID_W       (GRID_W),
    .GRID_H       (GRID_H),
    .START_BLOCK  (START_BLOCK),
    .TUNNEL_ROW   (TUNNEL_ROW),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .game_en    (game_en),
    .move_tick  (move_tick),
    .beh        (bus),
    .wall_addr  (wall_addr),
    .wall_q     (wall_q),
    .curr_block (curr_block),
    .moved      (moved),
    .blocked    (blocked),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Wall memory: synchronous read, data one cycle after the address.
  bit wall_mem [0:1023];
  always @(posedge clk) wall_q <= wall_mem[wall_addr];

  int checks = 0;
  int errors = 0;
  int pos;            // model of the committed position
  int exp_wall_addr;  // model of the last address driven to the wall memory

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_and_check_start(input string tag);
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    check({tag, ":start_hi"}, 32'(bus.start), 32'd1);
    @(negedge clk);
    check({tag, ":start_lo"}, 32'(bus.start), 32'd0);
  endtask

  // One full transaction; expectations come from row/column board rules.
  task automatic do_move(input int prop, input int delay, input bit drop, input string tag);
    int  r, c, pr, pc, tgt;
    bit  path, early, wall;
    r = pos / GRID_W;  c = pos % GRID_W;
    pr = prop / GRID_W; pc = prop % GRID_W;
    path = 1'b0; early = 1'b0; tgt = prop; wall = 1'b0;
    if (prop != pos) begin
      if (prop >= NUM_BLOCKS)
        early = 1'b1;
      else if ((pr == r && (pc - c == 1 || c - pc == 1)) ||
               (pc == c && (pr - r == 1 || r - pr == 1)))
        path = 1'b1;
      else if (r == TUNNEL_ROW && c == 0 && prop == pos - 1) begin
        path = 1'b1; tgt = r * GRID_W + GRID_W - 1;
      end else if (r == TUNNEL_ROW && c == GRID_W - 1 && prop == pos + 1) begin
        path = 1'b1; tgt = r * GRID_W;
      end else
        early = 1'b1;
    end

    tick_and_check_start(tag);
    if (drop) begin
      move_tick = 1'b1;
      @(negedge clk); move_tick = 1'b0;
      check({tag, ":drop_fault"}, 32'(fault), 32'd1);
    end
    repeat (delay) @(negedge clk);
    bus.done = 1'b1; bus.next_block = BLOCK_W'(prop);
    @(negedge clk);
    bus.done = 1'b0; bus.next_block = BLOCK_W'($urandom);
    if (path) exp_wall_addr = tgt;
    check({tag, ":early_blocked"}, 32'(blocked), 32'(early));
    check({tag, ":d1_moved"}, 32'(moved), 32'd0);
    check({tag, ":d1_fault"}, 32'(fault), 32'd0);
    check({tag, ":wall_addr"}, 32'(wall_addr), 32'(exp_wall_addr));
    @(negedge clk);
    check({tag, ":d2_pulses"}, 32'({moved, blocked}), 32'd0);
    @(negedge clk);
    if (path) wall = wall_mem[tgt];
    check({tag, ":moved"}, 32'(moved), 32'(path && !wall));
    check({tag, ":wall_blocked"}, 32'(blocked), 32'(path && wall));
    if (path && !wall) pos = tgt;
    check({tag, ":curr"}, 32'(curr_block), 32'(pos));
    @(negedge clk);
    check({tag, ":d4_pulses"}, 32'({moved, blocked}), 32'd0);
    check({tag, ":d4_curr"}, 32'(curr_block), 32'(pos));
  endtask

  initial begin
    int n;
    bit seen;
    int prop;

    reset = 1'b1; game_en = 1'b1; move_tick = 1'b0;
    bus.ready = 1'b1; bus.done = 1'b0; bus.next_block = '0;
    for (int i = 0; i < 1024; i++) wall_mem[i] = 1'b0;
    pos = START_BLOCK; exp_wall_addr = START_BLOCK;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst:curr", 32'(curr_block), 32'(START_BLOCK));
    check("rst:wall_addr", 32'(wall_addr), 32'(START_BLOCK));
    check("rst:outs", 32'({bus.start, moved, blocked, fault}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic moves and a wall hit
    do_move(496, 0, 1'b0, "right");
    do_move(495, 1, 1'b0, "left");
    wall_mem[463] = 1'b1;
    do_move(463, 2, 1'b0, "up_wall");

    // Tick while not ready: ignored, no fault
    bus.ready = 1'b0;
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("notready:start", 32'(bus.start), 32'd0);
      check("notready:fault", 32'(fault), 32'd0);
      @(negedge clk);
    end
    bus.ready = 1'b1;

    // Walk to the left edge of the tunnel row, wrap both ways
    for (int i = 0; i < 15; i++) do_move(pos - 1, 0, 1'b0, "walk_left");
    do_move(479, 0, 1'b0, "tunnel_left");
    do_move(512, 1, 1'b0, "tunnel_right");

    // Walk up column 0 to block 32, then edge rejects
    for (int i = 0; i < 14; i++) do_move(pos - GRID_W, 0, 1'b0, "walk_up");
    do_move(31, 0, 1'b0, "edge_left");
    do_move(960, 0, 1'b0, "out_of_range");

    // Tick dropped while busy, transaction still completes
    do_move(64, 1, 1'b1, "drop_tick");

    // done withheld: timeout fault, then a normal transaction
    tick_and_check_start("timeout");
    n = 1; seen = 1'b0;
    while (!seen && n < 4 * DONE_TIMEOUT) begin
      @(negedge clk); n++;
      if (fault === 1'b1) seen = 1'b1;
    end
    check("timeout:seen", 32'(seen), 32'd1);
    check("timeout:cycles", 32'(n), 32'(DONE_TIMEOUT + 1));
    @(negedge clk);
    check("timeout:one_pulse", 32'(fault), 32'd0);
    check("timeout:curr", 32'(curr_block), 32'(pos));
    do_move(32, 0, 1'b0, "after_timeout");

    // game_en dropped during LOOKUP
    tick_and_check_start("abort");
    bus.done = 1'b1; bus.next_block = BLOCK_W'(pos + GRID_W);
    @(negedge clk);
    bus.done = 1'b0; game_en = 1'b0;
    exp_wall_addr = pos + GRID_W;
    check("abort:wall_addr", 32'(wall_addr), 32'(exp_wall_addr));
    @(negedge clk);
    game_en = 1'b1;
    check("abort:d2_pulses", 32'({moved, blocked, fault}), 32'd0);
    @(negedge clk);
    check("abort:d3_pulses", 32'({moved, blocked, fault}), 32'd0);
    check("abort:curr", 32'(curr_block), 32'(pos));
    do_move(pos + GRID_W, 0, 1'b0, "after_abort");

    // Reset asserted in WAIT_DONE
    tick_and_check_start("rst_mid");
    reset = 1'b1;
    #1;
    check("rst_mid:curr", 32'(curr_block), 32'(START_BLOCK));
    check("rst_mid:start", 32'(bus.start), 32'd0);
    check("rst_mid:wall_addr", 32'(wall_addr), 32'(START_BLOCK));
    @(negedge clk);
    reset = 1'b0;
    pos = START_BLOCK; exp_wall_addr = START_BLOCK;
    @(negedge clk);
    do_move(497, 0, 1'b0, "two_steps");
    do_move(495, 0, 1'b0, "same_block");

    // Random proposals over a random maze
    for (int i = 0; i < 1024; i++) wall_mem[i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: prop = pos - GRID_W;
        1: prop = pos + GRID_W;
        2: prop = pos - 1;
        3: prop = pos + 1;
        4: prop = pos;
        5: prop = $urandom_range(NUM_BLOCKS, 1023);
        6: prop = $urandom_range(0, 1023);
        default: prop = ($urandom_range(0, 1) == 1) ? pos + 2 : pos - 2;
      endcase
      prop = prop & 1023;
      do_move(prop, $urandom_range(0, 3), 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
